// File: rtl/mc_fifo.sv
// mc_fifo: bank of independent first-word-fall-through FIFOs, one per channel.
//
// Each channel has its own storage array, read/write pointers, occupancy level
// and sticky overflow flag. The head entry of a non-empty channel is always
// presented on data_out. Status outputs (full, almost-full, valid) are flops
// loaded from the next-state level, so they always agree with the registered
// level output.
//
// Ports
//   clock                clock, all logic on its rising edge
//   rst_n                asynchronous active-low reset
//   data_in              write data, channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   data_in_valid        per-channel write request
//   data_in_full         per-channel full (level == BUFFER_SIZE)
//   data_in_almost_full  per-channel level >= ALMOST_FULL_LEVEL
//   data_out             per-channel head entry, same packing as data_in
//   data_out_valid       per-channel head valid (level != 0)
//   data_out_ack         per-channel pop of the head
//   flush                per-channel synchronous empty, highest priority
//   level                per-channel occupancy, channel c at [c*LEVEL_WIDTH +: LEVEL_WIDTH]
//   overflow             per-channel sticky flag, write attempted while full

module mc_fifo #(
    parameter int NUM_CHANNELS      = 4,
    parameter int BUFFER_SIZE       = 16,
    parameter int DATA_WIDTH        = 32,
    parameter int ALMOST_FULL_LEVEL = 14,
    localparam int LEVEL_WIDTH      = $clog2(BUFFER_SIZE + 1)
) (
    input  logic                                clock,
    input  logic                                rst_n,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]  data_in,
    input  logic [NUM_CHANNELS-1:0]             data_in_valid,
    output logic [NUM_CHANNELS-1:0]             data_in_full,
    output logic [NUM_CHANNELS-1:0]             data_in_almost_full,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0]  data_out,
    output logic [NUM_CHANNELS-1:0]             data_out_valid,
    input  logic [NUM_CHANNELS-1:0]             data_out_ack,
    input  logic [NUM_CHANNELS-1:0]             flush,
    output logic [NUM_CHANNELS*LEVEL_WIDTH-1:0] level,
    output logic [NUM_CHANNELS-1:0]             overflow
);

    localparam int PTR_WIDTH = $clog2(BUFFER_SIZE);

    localparam logic [PTR_WIDTH-1:0]   PTR_LAST = PTR_WIDTH'(BUFFER_SIZE - 1);
    localparam logic [LEVEL_WIDTH-1:0] LVL_FULL = LEVEL_WIDTH'(BUFFER_SIZE);
    localparam logic [LEVEL_WIDTH-1:0] LVL_AF   = LEVEL_WIDTH'(ALMOST_FULL_LEVEL);
    localparam logic [LEVEL_WIDTH-1:0] LVL_ONE  = LEVEL_WIDTH'(1);

    // Pointers wrap explicitly so BUFFER_SIZE need not be a power of two.
    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
        if (p == PTR_LAST)
            return '0;
        else
            return p + PTR_WIDTH'(1);
    endfunction

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch

        logic [DATA_WIDTH-1:0]  mem [BUFFER_SIZE];
        logic [PTR_WIDTH-1:0]   wr_ptr;
        logic [PTR_WIDTH-1:0]   rd_ptr;
        logic [LEVEL_WIDTH-1:0] lvl_q;
        logic [LEVEL_WIDTH-1:0] lvl_d;
        logic                   full_q;
        logic                   afull_q;
        logic                   valid_q;
        logic                   ovf_q;
        logic                   push;
        logic                   pop;
        logic                   wr_while_full;

        // A full channel rejects writes using the registered full flag, so a
        // same-cycle pop never makes room for a simultaneous push.
        assign push          = data_in_valid[c] & ~full_q & ~flush[c];
        assign pop           = valid_q & data_out_ack[c] & ~flush[c];
        assign wr_while_full = data_in_valid[c] & full_q & ~flush[c];

        always_comb begin
            lvl_d = lvl_q;
            if (flush[c])
                lvl_d = '0;
            else if (push && !pop)
                lvl_d = lvl_q + LVL_ONE;
            else if (pop && !push)
                lvl_d = lvl_q - LVL_ONE;
        end

        always_ff @(posedge clock or negedge rst_n) begin
            if (!rst_n) begin
                lvl_q   <= '0;
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                full_q  <= 1'b0;
                afull_q <= 1'b0;
                valid_q <= 1'b0;
                ovf_q   <= 1'b0;
            end else begin
                lvl_q   <= lvl_d;
                full_q  <= (lvl_d == LVL_FULL);
                afull_q <= (lvl_d >= LVL_AF);
                valid_q <= (lvl_d != '0);
                if (flush[c]) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    ovf_q  <= 1'b0;
                end else begin
                    if (push)
                        wr_ptr <= ptr_inc(wr_ptr);
                    if (pop)
                        rd_ptr <= ptr_inc(rd_ptr);
                    if (wr_while_full)
                        ovf_q <= 1'b1;
                end
            end
        end

        // Storage is deliberately not reset so it can map onto RAM.
        always_ff @(posedge clock) begin
            if (push)
                mem[wr_ptr] <= data_in[c*DATA_WIDTH +: DATA_WIDTH];
        end

        // Gating with valid forces data_out to zero while in reset or empty.
        assign data_out[c*DATA_WIDTH +: DATA_WIDTH]  = valid_q ? mem[rd_ptr] : '0;
        assign level[c*LEVEL_WIDTH +: LEVEL_WIDTH]   = lvl_q;
        assign data_in_full[c]                       = full_q;
        assign data_in_almost_full[c]                = afull_q;
        assign data_out_valid[c]                     = valid_q;
        assign overflow[c]                           = ovf_q;
    end

endmodule

// File: tb/tb_mc_fifo.sv
module tb_mc_fifo;

    localparam int NC = 4;
    localparam int BS = 16;
    localparam int DW = 32;
    localparam int AF = 14;
    localparam int LW = $clog2(BS + 1);

    logic                clock;
    logic                rst_n;
    logic [NC*DW-1:0]    data_in;
    logic [NC-1:0]       data_in_valid;
    logic [NC-1:0]       data_in_full;
    logic [NC-1:0]       data_in_almost_full;
    logic [NC*DW-1:0]    data_out;
    logic [NC-1:0]       data_out_valid;
    logic [NC-1:0]       data_out_ack;
    logic [NC-1:0]       flush;
    logic [NC*LW-1:0]    level;
    logic [NC-1:0]       overflow;

    mc_fifo #(
        .NUM_CHANNELS     (NC),
        .BUFFER_SIZE      (BS),
        .DATA_WIDTH       (DW),
        .ALMOST_FULL_LEVEL(AF)
    ) dut (
        .clock              (clock),
        .rst_n              (rst_n),
        .data_in            (data_in),
        .data_in_valid      (data_in_valid),
        .data_in_full       (data_in_full),
        .data_in_almost_full(data_in_almost_full),
        .data_out           (data_out),
        .data_out_valid     (data_out_valid),
        .data_out_ack       (data_out_ack),
        .flush              (flush),
        .level              (level),
        .overflow           (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected DUT outputs after one clock edge.
    typedef struct packed {
        logic [NC-1:0]    valid;
        logic [NC-1:0]    full;
        logic [NC-1:0]    afull;
        logic [NC-1:0]    ovf;
        logic [NC*LW-1:0] lvl;
        logic [NC*DW-1:0] data;
    } exp_t;

    exp_t             exp_q [$];
    logic [DW-1:0]    mq [NC][$];
    bit               movf [NC];
    int               n_checks = 0;
    int               n_fail   = 0;

    task automatic chk(input string nm, input int c, input logic [DW-1:0] act, input logic [DW-1:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s ch%0d: got %h expected %h at %0t", nm, c, act, expv, $time);
        end
    endtask

    function automatic logic [NC*DW-1:0] mk(input int c, input logic [DW-1:0] d);
        logic [NC*DW-1:0] v;
        v = '0;
        v[c*DW +: DW] = d;
        return v;
    endfunction

    // Reference model: a queue per channel, updated by the rules of one edge.
    task automatic step(input logic [NC-1:0] vin, input logic [NC-1:0] ack,
                        input logic [NC-1:0] fl, input logic [NC*DW-1:0] din);
        exp_t e;
        int   sz;
        bit   do_pop;
        bit   do_push;
        data_in_valid = vin;
        data_out_ack  = ack;
        flush         = fl;
        data_in       = din;
        e = '0;
        for (int c = 0; c < NC; c++) begin
            if (fl[c]) begin
                mq[c].delete();
                movf[c] = 0;
            end else begin
                sz      = mq[c].size();
                do_pop  = (sz != 0) && ack[c];
                do_push = vin[c] && (sz != BS);
                if (vin[c] && sz == BS)
                    movf[c] = 1;
                if (do_pop)
                    void'(mq[c].pop_front());
                if (do_push)
                    mq[c].push_back(din[c*DW +: DW]);
            end
            sz                 = mq[c].size();
            e.valid[c]         = (sz != 0);
            e.full[c]          = (sz == BS);
            e.afull[c]         = (sz >= AF);
            e.ovf[c]           = movf[c];
            e.lvl[c*LW +: LW]  = LW'(sz);
            e.data[c*DW +: DW] = (sz != 0) ? mq[c][0] : '0;
        end
        @(posedge clock);
        exp_q.push_back(e);
        #1;
    endtask

    // Monitor: compares the DUT against each expected record after its edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (rst_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int c = 0; c < NC; c++) begin
                    chk("level", c, DW'(level[c*LW +: LW]), DW'(e.lvl[c*LW +: LW]));
                    chk("valid", c, DW'(data_out_valid[c]), DW'(e.valid[c]));
                    chk("full", c, DW'(data_in_full[c]), DW'(e.full[c]));
                    chk("almost_full", c, DW'(data_in_almost_full[c]), DW'(e.afull[c]));
                    chk("overflow", c, DW'(overflow[c]), DW'(e.ovf[c]));
                    if (e.valid[c])
                        chk("data_out", c, data_out[c*DW +: DW], e.data[c*DW +: DW]);
                end
            end
        end
    end

    task automatic chk_reset();
        for (int c = 0; c < NC; c++) begin
            chk("rst_level", c, DW'(level[c*LW +: LW]), '0);
            chk("rst_valid", c, DW'(data_out_valid[c]), '0);
            chk("rst_full", c, DW'(data_in_full[c]), '0);
            chk("rst_almost_full", c, DW'(data_in_almost_full[c]), '0);
            chk("rst_overflow", c, DW'(overflow[c]), '0);
            chk("rst_data_out", c, data_out[c*DW +: DW], '0);
        end
    endtask

    task automatic rand_step(input int ack_thr);
        logic [NC-1:0]    vin;
        logic [NC-1:0]    ack;
        logic [NC-1:0]    fl;
        logic [NC*DW-1:0] din;
        for (int c = 0; c < NC; c++) begin
            vin[c]          = ($urandom_range(0, 3) != 0);
            ack[c]          = ($urandom_range(0, 3) < ack_thr);
            fl[c]           = ($urandom_range(0, 39) == 0);
            din[c*DW +: DW] = $urandom;
        end
        step(vin, ack, fl, din);
    endtask

    initial begin
        rst_n         = 1'b0;
        data_in       = '0;
        data_in_valid = '0;
        data_out_ack  = '0;
        flush         = '0;
        #2;
        chk_reset();
        #6;
        rst_n = 1'b1;

        // ch0: FWFT with ack held high, level never exceeds 1
        step(4'b0001, 4'b0001, 4'b0000, mk(0, 32'h11));
        step(4'b0001, 4'b0001, 4'b0000, mk(0, 32'h22));
        step(4'b0001, 4'b0001, 4'b0000, mk(0, 32'h33));
        step(4'b0000, 4'b0001, 4'b0000, '0);

        // ch1: fill to full, then overflow with 0xDEAD, then drain
        for (int i = 0; i < BS; i++)
            step(4'b0010, 4'b0000, 4'b0000, mk(1, 32'h100 + i));
        step(4'b0010, 4'b0000, 4'b0000, mk(1, 32'hDEAD));
        for (int i = 0; i < BS + 1; i++)
            step(4'b0000, 4'b0010, 4'b0000, '0);

        // ch2: full with simultaneous push/ack, then refill across the wrap
        for (int i = 0; i < BS; i++)
            step(4'b0100, 4'b0000, 4'b0000, mk(2, 32'h200 + i));
        step(4'b0100, 4'b0100, 4'b0000, mk(2, 32'hBAD0));
        step(4'b0100, 4'b0000, 4'b0000, mk(2, 32'h2FF));
        for (int i = 0; i < BS + 1; i++)
            step(4'b0000, 4'b0100, 4'b0000, '0);

        // ch3: 5 entries, then flush together with push and ack
        for (int i = 0; i < 5; i++)
            step(4'b1011, 4'b0000, 4'b0000,
                 mk(0, 32'h300 + i) | mk(1, 32'h310 + i) | mk(3, 32'h330 + i));
        step(4'b1111, 4'b1000, 4'b1000, mk(3, 32'hF1F1) | mk(2, 32'h444));
        step(4'b0000, 4'b0000, 4'b0000, '0);
        step(4'b0000, 4'b0111, 4'b0000, '0);

        // randomized traffic alternating fill-heavy and drain-heavy phases
        for (int ph = 0; ph < 16; ph++)
            for (int i = 0; i < 100; i++)
                rand_step((ph % 2 == 0) ? 1 : 3);

        // asynchronous reset in the middle of a burst
        for (int i = 0; i < 20; i++)
            rand_step(1);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk_reset();
        @(posedge clock);
        #1;
        chk_reset();
        @(posedge clock);
        #2;
        rst_n = 1'b1;
        for (int c = 0; c < NC; c++) begin
            mq[c].delete();
            movf[c] = 0;
        end
        step(4'b0001, 4'b0000, 4'b0000, mk(0, 32'hA5));
        step(4'b0001, 4'b0000, 4'b0000, mk(0, 32'hA6));
        step(4'b0000, 4'b0001, 4'b0000, '0);
        step(4'b0000, 4'b0001, 4'b0000, '0);
        for (int i = 0; i < 200; i++)
            rand_step(2);

        data_in_valid = '0;
        data_out_ack  = '0;
        flush         = '0;
        repeat (3) @(posedge clock);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected records left unchecked, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
